hazard_ctrl: RTL

- Pipeline sequencing controller for the 16-bit, 6-stage core (IF, ID, EX1, EX2, MEM, WB), which has no forwarding.
- Keeps a destination scoreboard that shadows the EX1..WB stages and detects RAW hazards for the instruction in ID.
- Drives stall_if/stall_id/flush_id/flush_ex/flush_ex1 and the PC redirect for branches resolved in EX2.
- Runs a debug freeze/drain handshake and keeps saturating stall and flush counters.

---
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Brief   : RAW-hazard stall, branch redirect/flush and debug freeze control
//           for the 6-stage, non-forwarding 16-bit core.
// Revision: 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic [15:0]       br_target,
    input  logic              freeze_req,
    input  logic              cnt_clr,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              flush_ex1,
    output logic              redirect,
    output logic [15:0]       redirect_pc,
    output logic              freeze_ack,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    localparam int               SB_DEPTH = 4;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Scoreboard entry k shadows stage EX1+k (EX1, EX2, MEM, WB).
    logic [SB_DEPTH-1:0] r_sb_v;
    logic [REG_AW-1:0]   r_sb_rd [SB_DEPTH];

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ack;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic [SB_DEPTH-1:0] w_hit;
    logic                w_redirect;
    logic                w_haz;
    logic                w_stall;
    logic                w_issue;
    logic                w_src1_live;
    logic                w_src2_live;

    assign w_redirect  = br_valid & br_taken;
    assign w_src1_live = id_use_rs1 & (id_rs1 != '0);
    assign w_src2_live = id_use_rs2 & (id_rs2 != '0);

    generate
        for (genvar k = 0; k < SB_DEPTH; k++) begin : g_hit
            assign w_hit[k] = r_sb_v[k] &
                              ((w_src1_live & (r_sb_rd[k] == id_rs1)) |
                               (w_src2_live & (r_sb_rd[k] == id_rs2)));
        end
    endgenerate

    assign w_haz   = id_valid & ~w_redirect & (|w_hit);
    // A taken branch overrides every stall source so the flush can land.
    assign w_stall = ~w_redirect & (w_haz | (r_state != ST_RUN));
    assign w_issue = id_valid & id_reg_write & (id_rd != '0) & ~w_stall & ~w_redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sb_v <= '0;
            for (int k = 0; k < SB_DEPTH; k++) begin
                r_sb_rd[k] <= '0;
            end
        end else begin
            r_sb_v[0]  <= w_issue;
            r_sb_rd[0] <= id_rd;
            // The EX1 occupant is younger than the resolving branch: kill it.
            r_sb_v[1]  <= r_sb_v[0] & ~w_redirect;
            r_sb_rd[1] <= r_sb_rd[0];
            r_sb_v[2]  <= r_sb_v[1];
            r_sb_rd[2] <= r_sb_rd[1];
            r_sb_v[3]  <= r_sb_v[2];
            r_sb_rd[3] <= r_sb_rd[2];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= (w_state_nxt == ST_FROZEN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (freeze_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!freeze_req) begin
                    w_state_nxt = ST_RUN;
                end else if (r_sb_v == '0) begin
                    w_state_nxt = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (!freeze_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_haz && (r_state == ST_RUN) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign stall_if    = w_stall;
    assign stall_id    = w_stall;
    assign flush_id    = w_redirect;
    assign flush_ex    = w_redirect;
    assign flush_ex1   = w_redirect;
    assign redirect    = w_redirect;
    assign redirect_pc = w_redirect ? br_target : 16'h0000;
    assign freeze_ack  = r_ack;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire
